// File: rtl/counter_pkg.sv
// Shared types and constants for the synchronised up/down counter.
package counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SATURATE} count_mode_e;

    localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_bit_n.sv
// N-flop synchroniser for a single asynchronous control bit.
module sync_bit_n #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/sync_updown_counter.sv
// Up/down counter with programmable limit, wrap/saturate mode and one-shot load,
// fed by synchronised asynchronous control inputs.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter count_mode_e MODE        = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc_pulse,
    output logic             bound_flag
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("sync_updown_counter: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end

    if (WIDTH < 2) begin : g_bad_width
        $error("sync_updown_counter: WIDTH must be >= 2");
    end

    logic sync_pause;
    logic sync_dir;
    logic sync_load;
    logic load_prev;
    logic load_evt;

    sync_bit_n #(.STAGES(SYNC_STAGES)) u_sync_pause (
        .clk   (clk),
        .reset (reset),
        .d     (pause),
        .q     (sync_pause)
    );

    sync_bit_n #(.STAGES(SYNC_STAGES)) u_sync_dir (
        .clk   (clk),
        .reset (reset),
        .d     (dir),
        .q     (sync_dir)
    );

    sync_bit_n #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk   (clk),
        .reset (reset),
        .d     (load),
        .q     (sync_load)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_prev <= 1'b0;
        end else begin
            load_prev <= sync_load;
        end
    end

    assign load_evt = sync_load & ~load_prev;

    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             bf_nxt;

    // Compare against the bounds before stepping so no carry/borrow is needed.
    always_comb begin
        cnt_nxt = counter_out;
        tc_nxt  = 1'b0;
        bf_nxt  = bound_flag;
        if (load_evt) begin
            cnt_nxt = (parallel_in > limit) ? limit : parallel_in;
            bf_nxt  = 1'b0;
        end else if (!sync_pause) begin
            if (!sync_dir) begin
                if (counter_out < limit) begin
                    cnt_nxt = counter_out + 1'b1;
                end else begin
                    cnt_nxt = (MODE == CNT_SATURATE) ? limit : '0;
                    tc_nxt  = 1'b1;
                    bf_nxt  = 1'b1;
                end
            end else begin
                if (counter_out != '0) begin
                    cnt_nxt = counter_out - 1'b1;
                end else begin
                    cnt_nxt = (MODE == CNT_SATURATE) ? '0 : limit;
                    tc_nxt  = 1'b1;
                    bf_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_out <= '0;
            tc_pulse    <= 1'b0;
            bound_flag  <= 1'b0;
        end else begin
            counter_out <= cnt_nxt;
            tc_pulse    <= tc_nxt;
            bound_flag  <= bf_nxt;
        end
    end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Randomised self-checking bench: a wrap/2-stage and a saturate/3-stage counter
// share stimulus and are compared against a history-based reference model.
module tb_sync_updown_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pause = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] parallel_in = '0;
    logic [7:0] limit = 8'd9;

    logic [7:0] cnt_w;
    logic       tc_w;
    logic       bf_w;
    logic [7:0] cnt_s;
    logic       tc_s;
    logic       bf_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(8), .SYNC_STAGES(2), .MODE(CNT_WRAP)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .dir         (dir),
        .load        (load),
        .parallel_in (parallel_in),
        .limit       (limit),
        .counter_out (cnt_w),
        .tc_pulse    (tc_w),
        .bound_flag  (bf_w)
    );

    sync_updown_counter #(.WIDTH(8), .SYNC_STAGES(3), .MODE(CNT_SATURATE)) dut_s (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .dir         (dir),
        .load        (load),
        .parallel_in (parallel_in),
        .limit       (limit),
        .counter_out (cnt_s),
        .tc_pulse    (tc_s),
        .bound_flag  (bf_s)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Control history: entry n holds {pause,dir,load} present at clock edge n since reset release.
    bit [2:0] hist[$];
    int       m_stages[2] = '{2, 3};
    bit       m_sat[2]    = '{1'b0, 1'b1};
    int       m_cnt[2];
    bit       m_tc[2];
    bit       m_bf[2];

    function automatic bit [2:0] seen(input int idx);
        if (idx < 0) return 3'b000;
        return hist[idx];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 1'b0;
            m_bf[i]  = 1'b0;
        end
    endtask

    // A control value present at edge n is acted on at edge n+stages.
    task automatic model_edge();
        int n;
        int lim;
        int pin;
        bit [2:0] cur;
        bit [2:0] prv;
        hist.push_back({pause, dir, load});
        n   = hist.size() - 1;
        lim = int'(limit);
        pin = int'(parallel_in);
        for (int i = 0; i < 2; i++) begin
            cur = seen(n - m_stages[i]);
            prv = seen(n - m_stages[i] - 1);
            m_tc[i] = 1'b0;
            if (cur[0] && !prv[0]) begin
                m_cnt[i] = (pin > lim) ? lim : pin;
                m_bf[i]  = 1'b0;
            end else if (!cur[2]) begin
                if (!cur[1]) begin
                    if (m_cnt[i] < lim) begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end else begin
                        m_cnt[i] = m_sat[i] ? lim : 0;
                        m_tc[i]  = 1'b1;
                        m_bf[i]  = 1'b1;
                    end
                end else begin
                    if (m_cnt[i] > 0) begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end else begin
                        m_cnt[i] = m_sat[i] ? 0 : lim;
                        m_tc[i]  = 1'b1;
                        m_bf[i]  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_value("wrap_count", 32'(cnt_w), 32'(m_cnt[0]));
        check_value("wrap_tc",    32'(tc_w),  32'(m_tc[0]));
        check_value("wrap_flag",  32'(bf_w),  32'(m_bf[0]));
        check_value("sat_count",  32'(cnt_s), 32'(m_cnt[1]));
        check_value("sat_tc",     32'(tc_s),  32'(m_tc[1]));
        check_value("sat_flag",   32'(bf_s),  32'(m_bf[1]));
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
    task automatic run_cycles(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_wcnt"}, 32'(cnt_w), 32'd0);
        check_value({tag, "_wtc"},  32'(tc_w),  32'd0);
        check_value({tag, "_wbf"},  32'(bf_w),  32'd0);
        check_value({tag, "_scnt"}, 32'(cnt_s), 32'd0);
        check_value({tag, "_stc"},  32'(tc_s),  32'd0);
        check_value({tag, "_sbf"},  32'(bf_s),  32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // Free count against limit 9 through a wrap.
        run_cycles(14);
        check_value("wrap_seen_flag", 32'(bf_w), 32'd1);

        // Load above the limit is clamped; held load acts once.
        parallel_in = 8'd200;
        load = 1'b1;
        run_cycles(1);
        load = 1'b0;
        run_cycles(5);
        check_value("clamped_load", 32'(cnt_w), 32'(m_cnt[0]));
        load = 1'b1;
        parallel_in = 8'd3;
        run_cycles(10);
        load = 1'b0;
        run_cycles(4);

        // Saturate downwards from a low load value.
        limit = 8'd5;
        parallel_in = 8'd2;
        dir = 1'b1;
        load = 1'b1;
        run_cycles(1);
        load = 1'b0;
        run_cycles(10);
        check_value("sat_hold_zero", 32'(cnt_s), 32'd0);
        check_value("sat_repeat_tc", 32'(tc_s), 32'd1);

        // Load and pause together: load wins, then hold.
        parallel_in = 8'd7;
        limit = 8'd9;
        load = 1'b1;
        pause = 1'b1;
        run_cycles(8);
        check_value("load_then_pause", 32'(cnt_w), 32'd7);
        load = 1'b0;
        pause = 1'b0;
        dir = 1'b0;
        run_cycles(5);

        // Degenerate limits.
        limit = 8'd0;
        run_cycles(6);
        limit = 8'hFF;
        run_cycles(20);

        // Randomised operation with periodic reset.
        for (int blk = 0; blk < 12; blk++) begin
            case ($urandom_range(0, 4))
                0:       limit = 8'd0;
                1:       limit = 8'hFF;
                2:       limit = 8'($urandom_range(0, 255));
                default: limit = 8'($urandom_range(1, 20));
            endcase
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 99) < 10) pause = ~pause;
                if ($urandom_range(0, 99) < 6) dir = ~dir;
                if ($urandom_range(0, 99) < 8) load = ~load;
                parallel_in = 8'($urandom_range(0, 255));
                run_cycles(1);
            end
            if (blk % 4 == 3) apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
